formula_stream_out: RTL and testbench

- Serialises a stored `formula` back into the same two-word-per-clause literal stream that `read_store` consumes.
- Each clause is sent as a positive-literal mask word, then a negative-literal mask word.
- The stream ends with an all-zero terminator pair.
- Sits on the solver output side: dumps the simplified or partially assigned formula to a host/logger, or loops it back into another `read_store` for self-check.

---
 rtl/formula_stream_out_pkg.sv | 31 +++
 rtl/formula_stream_out_if.sv | 12 +
 rtl/formula_stream_out_next_nonempty_clause.sv | 23 ++
 rtl/formula_stream_out.sv | 140 ++++++++++++++
 tb/tb_formula_stream_out.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/formula_stream_out_pkg.sv
// Shared types and sizes for the formula stream transmitter.
// A formula is a fixed array of clauses, each a positive and a negative literal mask.
package formula_stream_out_pkg;

    localparam int unsigned number_literal = 5;
    localparam int unsigned number_clause  = 8;
    localparam int unsigned count_w        = $clog2(number_clause + 1);
    localparam int unsigned idx_w          = $clog2(number_clause);

    typedef struct packed {
        logic [number_literal-1:0] pos;
        logic [number_literal-1:0] neg;
    } clause_t;

    typedef clause_t [number_clause-1:0] formula_t;

    typedef logic [2:0] tx_state_t;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] SEND_POS = 3'd1;
    localparam logic [2:0] SEND_NEG = 3'd2;
    localparam logic [2:0] END0     = 3'd3;
    localparam logic [2:0] END1     = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    // An all-zero clause would be indistinguishable from the terminator pair.
    function automatic logic clause_empty(input clause_t c);
        return (c.pos == '0) && (c.neg == '0);
    endfunction

endpackage

// File: rtl/formula_stream_out_if.sv
// Valid/ready literal-word stream carrying a serialised formula.
interface formula_stream_out_if;
    import formula_stream_out_pkg::*;

    logic [number_literal-1:0] o;
    logic                      o_valid;
    logic                      o_ready;

    modport master (output o, output o_valid, input o_ready);
    modport slave  (input o, input o_valid, output o_ready);

endinterface

// File: rtl/formula_stream_out_next_nonempty_clause.sv
// Priority encoder: lowest clause index at or above `first` that is non-empty.
module formula_stream_out_next_nonempty_clause
    import formula_stream_out_pkg::*;
(
    input  formula_t           formula,
    input  logic [count_w-1:0] first,
    output logic               found_c,
    output logic [idx_w-1:0]   index_c
);

    // Descending scan so the lowest qualifying index is the last one written.
    always_comb begin
        found_c = 1'b0;
        index_c = '0;
        for (int i = number_clause - 1; i >= 0; i--) begin
            if ((count_w'(i) >= first) && !clause_empty(formula[i])) begin
                found_c = 1'b1;
                index_c = idx_w'(i);
            end
        end
    end

endmodule

// File: rtl/formula_stream_out.sv
// Streams a snapshotted formula as pos/neg mask word pairs, skipping empty clauses,
// followed by an all-zero terminator pair and a one-cycle done pulse.
module formula_stream_out
    import formula_stream_out_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  formula_t                   formula_in,
    formula_stream_out_if.master       tx,
    output logic                       busy,
    output logic                       done,
    output logic [count_w-1:0]         clauses_sent
);

    tx_state_t                 state, state_nx;
    logic [idx_w-1:0]          idx, idx_nx;
    formula_t                  snapshot, snapshot_nx;
    logic [count_w-1:0]        count_nx;
    logic [number_literal-1:0] o_nx;
    logic                      valid_nx;
    logic                      busy_nx;
    logic                      done_nx;
    logic                      accept;

    formula_t                  scan_src;
    logic [count_w-1:0]        scan_first;
    logic                      found;
    logic [idx_w-1:0]          found_idx;

    formula_stream_out_next_nonempty_clause u_next (
        .formula (scan_src),
        .first   (scan_first),
        .found_c (found),
        .index_c (found_idx)
    );

    // Next-state and next-output logic; outputs are registered from the *_nx values.
    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        snapshot_nx = snapshot;
        count_nx    = clauses_sent;
        o_nx        = tx.o;
        valid_nx    = tx.o_valid;
        busy_nx     = busy;
        done_nx     = 1'b0;
        scan_src    = snapshot;
        scan_first  = count_w'(idx) + count_w'(1);
        accept      = tx.o_valid && tx.o_ready;

        case (state)
            IDLE: begin
                // The live input is searched so the first word is ready the next cycle.
                scan_src   = formula_in;
                scan_first = '0;
                if (start) begin
                    snapshot_nx = formula_in;
                    count_nx    = '0;
                    busy_nx     = 1'b1;
                    valid_nx    = 1'b1;
                    if (found) begin
                        state_nx = SEND_POS;
                        idx_nx   = found_idx;
                        o_nx     = formula_in[found_idx].pos;
                    end else begin
                        state_nx = END0;
                        idx_nx   = '0;
                        o_nx     = '0;
                    end
                end
            end
            SEND_POS: begin
                if (accept) begin
                    state_nx = SEND_NEG;
                    o_nx     = snapshot[idx].neg;
                end
            end
            SEND_NEG: begin
                if (accept) begin
                    count_nx = clauses_sent + count_w'(1);
                    if (found) begin
                        state_nx = SEND_POS;
                        idx_nx   = found_idx;
                        o_nx     = snapshot[found_idx].pos;
                    end else begin
                        state_nx = END0;
                        o_nx     = '0;
                    end
                end
            end
            END0: begin
                if (accept) begin
                    state_nx = END1;
                    o_nx     = '0;
                end
            end
            END1: begin
                if (accept) begin
                    state_nx = DONE;
                    valid_nx = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            DONE: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
            default: begin
                state_nx = IDLE;
                valid_nx = 1'b0;
                busy_nx  = 1'b0;
                o_nx     = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idx          <= '0;
            snapshot     <= '0;
            clauses_sent <= '0;
            tx.o         <= '0;
            tx.o_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            snapshot     <= snapshot_nx;
            clauses_sent <= count_nx;
            tx.o         <= o_nx;
            tx.o_valid   <= valid_nx;
            busy         <= busy_nx;
            done         <= done_nx;
        end
    end

endmodule

// File: tb/tb_formula_stream_out.sv
// Scoreboard bench for formula_stream_out: a clause-level model queues expected words
// and clause counts; an independent monitor checks every accepted word and done pulse.
module tb_formula_stream_out;
    import formula_stream_out_pkg::*;

    logic               clk;
    logic               reset;
    logic               start;
    formula_t           formula_in;
    logic               busy;
    logic               done;
    logic [count_w-1:0] clauses_sent;

    formula_stream_out_if tx();

    formula_stream_out dut (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .formula_in   (formula_in),
        .tx           (tx),
        .busy         (busy),
        .done         (done),
        .clauses_sent (clauses_sent)
    );

    int n_checks = 0;
    int n_errors = 0;
    int ready_mode = 0;  // 0 always ready, 1 random, 2 held low

    logic [number_literal-1:0] exp_words[$];
    int                        exp_counts[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: every non-empty clause in index order as pos then neg, then two zero words.
    function automatic int model_push(input formula_t f);
        int n = 0;
        for (int i = 0; i < int'(number_clause); i++) begin
            if (f[i].pos != '0 || f[i].neg != '0) begin
                exp_words.push_back(f[i].pos);
                exp_words.push_back(f[i].neg);
                n++;
            end
        end
        exp_words.push_back('0);
        exp_words.push_back('0);
        exp_counts.push_back(n);
        return n;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tx.o_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       tx.o_ready = 1'b1;
                1:       tx.o_ready = ($urandom_range(3) != 0);
                default: tx.o_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops on each accepted word, checks stall stability and the done count.
    logic                      prev_stall = 1'b0;
    logic [number_literal-1:0] prev_o = '0;
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(tx.o_valid), 32'd1);
                check("stall_word_held", 32'(tx.o), 32'(prev_o));
            end
            if (tx.o_valid && tx.o_ready) begin
                if (exp_words.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got %0h required none", tx.o);
                end else begin
                    check("stream_word", 32'(tx.o), 32'(exp_words.pop_front()));
                end
            end
            prev_stall = tx.o_valid && !tx.o_ready;
            prev_o     = tx.o;
            if (done) begin
                if (exp_counts.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got 1 required 0");
                end else begin
                    check("clauses_sent_at_done", 32'(clauses_sent), 32'(exp_counts.pop_front()));
                end
                check("words_left_at_done", 32'(exp_words.size()), 32'd0);
            end
        end
    end

    // Pulse start with f, optionally disturb inputs or apply a 3-cycle stall on 00010.
    task automatic run(input formula_t f, input bit disturb, input bit bp, output int busy_cycles);
        int bp_left = 0;
        bit ok = 1'b0;
        void'(model_push(f));
        formula_in = f;
        start      = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        busy_cycles = 0;
        for (int c = 0; c < 1000; c++) begin
            if (busy) busy_cycles++;
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (disturb) begin
                formula_in = formula_t'({$urandom(), $urandom(), $urandom()});
                start      = ($urandom_range(2) == 0);
            end
            if (bp_left > 0) begin
                check("bp_valid", 32'(tx.o_valid), 32'd1);
                check("bp_word", 32'(tx.o), 32'h02);
                bp_left--;
                if (bp_left == 0) ready_mode = 0;
            end else if (bp && tx.o_valid && tx.o == 5'b00001) begin
                ready_mode = 2;
                bp_left    = 3;
                bp         = 1'b0;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL done_timeout: got no done required done");
        end
        // A start during the done cycle must be ignored.
        start = disturb;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        check("valid_after_done", 32'(tx.o_valid), 32'd0);
    endtask

    function automatic int nonempty(input formula_t f);
        int n = 0;
        for (int i = 0; i < int'(number_clause); i++)
            if (f[i].pos != '0 || f[i].neg != '0) n++;
        return n;
    endfunction

    formula_t f1, f2, f3, f4, fr;
    int       bc;
    bit       seen;

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        formula_in = '0;
        repeat (3) @(negedge clk);
        check("rst_o", 32'(tx.o), 32'd0);
        check("rst_valid", 32'(tx.o_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(clauses_sent), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        f1 = '0;
        f1[0] = '{pos: 5'b11100, neg: 5'b00000};
        f1[1] = '{pos: 5'b00000, neg: 5'b11100};
        f1[2] = '{pos: 5'b00001, neg: 5'b00010};
        run(f1, 1'b0, 1'b0, bc);
        check("basic_busy_cycles", 32'(bc), 32'd9);
        repeat (3) @(negedge clk);
        check("count_holds", 32'(clauses_sent), 32'd3);

        f2 = '0;
        f2[0] = '{pos: 5'b00010, neg: 5'b10000};
        f2[4] = '{pos: 5'b01100, neg: 5'b00000};
        run(f2, 1'b0, 1'b0, bc);
        check("skip_busy_cycles", 32'(bc), 32'd7);

        f3 = '0;
        run(f3, 1'b0, 1'b0, bc);
        check("empty_busy_cycles", 32'(bc), 32'd3);
        check("empty_count", 32'(clauses_sent), 32'd0);

        for (int i = 0; i < int'(number_clause); i++)
            f4[i] = '{pos: 5'(i + 1), neg: 5'($urandom())};
        f4[number_clause-1] = '{pos: 5'b00000, neg: 5'b10101};
        run(f4, 1'b0, 1'b0, bc);
        check("full_busy_cycles", 32'(bc), 32'(2 * number_clause + 3));
        check("full_count", 32'(clauses_sent), 32'(number_clause));

        run(f1, 1'b0, 1'b1, bc);
        check("bp_busy_cycles", 32'(bc), 32'd12);

        run(f1, 1'b1, 1'b0, bc);
        check("robust_busy_cycles", 32'(bc), 32'd9);

        // Reset while the first terminator word is on the bus.
        f2 = '0;
        f2[0] = '{pos: 5'b01010, neg: 5'b00101};
        void'(model_push(f2));
        formula_in = f2;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen  = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (tx.o_valid && tx.o == '0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("reached_end0", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(tx.o_valid), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        exp_words.delete();
        exp_counts.delete();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run(f2, 1'b0, 1'b0, bc);
        check("after_rst_busy_cycles", 32'(bc), 32'd5);

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < int'(number_clause); i++) begin
                if ($urandom_range(2) == 0) fr[i] = '0;
                else fr[i] = clause_t'($urandom());
            end
            ready_mode = $urandom_range(1);
            run(fr, 1'($urandom_range(1)), 1'b0, bc);
            if (ready_mode == 0)
                check("rand_busy_cycles", 32'(bc), 32'(2 * nonempty(fr) + 3));
            ready_mode = 0;
        end

        check("final_words_empty", 32'(exp_words.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
